// File: rtl/rcvr_pkg.sv
// Shared types and constants for the receive frame controller and its CRC unit.
package rcvr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEST,
        ST_SRC,
        ST_TYPE,
        ST_DATA,
        ST_CHECK
    } rx_state_t;

    localparam logic [7:0] BCAST_ADDR  = 8'h2A;
    localparam logic [7:0] ACK_TYPE    = 8'h33;
    localparam logic [7:0] ACKREQ_TYPE = 8'h32;
    localparam logic [7:0] CRC_RESIDUE = 8'h00;
    localparam logic [7:0] CRC_POLY    = 8'h07;

    // One byte of CRC-8 (x^8+x^2+x+1), MSB first, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_lookup.sv
// Registered byte-wide CRC-8 accumulator with clear and enable.
module crc_lookup
    import rcvr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       enb,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= 8'h00;
        end else if (enb) begin
            crc <= crc8_byte(crc, data);
        end
    end

endmodule

// File: rtl/rcvr_frame_ctrl.sv
// Receive frame controller: address filter, CRC check, one-frame buffer, ACK handshake.
// Define RCVR_PROMISC_EN to bypass the address filter for committing good frames.
module rcvr_frame_ctrl
    import rcvr_pkg::*;
#(
    parameter int unsigned MAX_DATA = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       cardet,
    input  logic       rx_error,
    input  logic [7:0] mac,
    output logic [7:0] rdata,
    output logic       rvalid,
    input  logic       rrdy,
    output logic       ack_needed,
    output logic [7:0] ack_addr,
    output logic       ack_received,
    output logic [7:0] rerrcnt
);

    localparam int unsigned DEPTH = MAX_DATA + 1;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = $clog2(DEPTH + 1);

    rx_state_t     state;
    logic          cardet_q;
    logic [7:0]    dest_q, src_q, type_q;
    logic [PW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr, len;
    logic          err, full;
    logic [7:0]    crc;
    logic [7:0]    mem [DEPTH];

    logic          cardet_rise_c, cardet_fall_c, in_frame_c, end_c;
    logic          crc_clr_c, crc_enb_c, wr_en_c;
    logic          frame_err_c, addr_hit_c, for_us_c, crc_ok_c, ack_frame_c;
    logic          commit_c, ack_req_c, ack_rcv_c, err_cnt_c;
    logic [AW-1:0] data_len_c;

    crc_lookup u_crc (
        .clk  (clk),
        .rst  (rst),
        .clr  (crc_clr_c),
        .enb  (crc_enb_c),
        .data (rx_data),
        .crc  (crc)
    );

    // End-of-frame decision is made on the cardet-falling cycle so its results are visible in CHECK.
    always_comb begin
        cardet_rise_c = cardet & ~cardet_q;
        cardet_fall_c = ~cardet & cardet_q;
        in_frame_c    = (state != ST_IDLE) && (state != ST_CHECK);
        end_c         = in_frame_c & cardet_fall_c;
        crc_clr_c     = (state == ST_IDLE) & cardet_rise_c;
        crc_enb_c     = in_frame_c & rx_valid & ~cardet_fall_c;
        wr_en_c       = (state == ST_DATA) & rx_valid & ~cardet_fall_c & ~err
                        & (wr_ptr != PW'(DEPTH));
        frame_err_c   = err | rx_error | (state != ST_DATA) | (wr_ptr == PW'(0));
        for_us_c      = (dest_q == mac);
`ifdef RCVR_PROMISC_EN
        addr_hit_c    = 1'b1;
`else
        addr_hit_c    = for_us_c | (dest_q == BCAST_ADDR);
`endif
        crc_ok_c      = (crc == CRC_RESIDUE);
        ack_frame_c   = (type_q == ACK_TYPE) & for_us_c;
        data_len_c    = AW'(wr_ptr - PW'(1));
        err_cnt_c     = end_c & (frame_err_c | (addr_hit_c & ~crc_ok_c));
        ack_rcv_c     = end_c & ~frame_err_c & crc_ok_c & ack_frame_c;
        commit_c      = end_c & ~frame_err_c & addr_hit_c & crc_ok_c & ~ack_frame_c
                        & (data_len_c != AW'(0));
        ack_req_c     = end_c & ~frame_err_c & crc_ok_c & for_us_c & (type_q == ACKREQ_TYPE);
    end

    // Receive FSM, header latches, error counter and ACK outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cardet_q     <= 1'b0;
            dest_q       <= 8'h00;
            src_q        <= 8'h00;
            type_q       <= 8'h00;
            wr_ptr       <= '0;
            err          <= 1'b0;
            ack_needed   <= 1'b0;
            ack_received <= 1'b0;
            ack_addr     <= 8'h00;
            rerrcnt      <= 8'h00;
        end else begin
            cardet_q     <= cardet;
            ack_needed   <= ack_req_c;
            ack_received <= ack_rcv_c;
            if (ack_req_c) ack_addr <= src_q;
            if (err_cnt_c && rerrcnt != 8'hFF) rerrcnt <= rerrcnt + 8'd1;
            case (state)
                ST_IDLE: begin
                    if (cardet_rise_c) begin
                        state  <= ST_DEST;
                        wr_ptr <= '0;
                        err    <= full;
                    end
                end
                ST_CHECK: state <= ST_IDLE;
                default: begin
                    if (rx_error) err <= 1'b1;
                    if (cardet_fall_c) begin
                        state <= ST_CHECK;
                    end else if (rx_valid) begin
                        case (state)
                            ST_DEST: begin dest_q <= rx_data; state <= ST_SRC;  end
                            ST_SRC:  begin src_q  <= rx_data; state <= ST_TYPE; end
                            ST_TYPE: begin type_q <= rx_data; state <= ST_DATA; end
                            ST_DATA: begin
                                if (wr_ptr == PW'(DEPTH)) err <= 1'b1;
                                else                      wr_ptr <= wr_ptr + PW'(1);
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) mem[AW'(wr_ptr)] <= rx_data;
    end

    // Drain side: registered read, next address chosen so back-to-back transfers stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= 8'h00;
            rd_ptr <= '0;
            len    <= '0;
        end else if (commit_c) begin
            full   <= 1'b1;
            len    <= data_len_c;
            rd_ptr <= '0;
        end else if (full) begin
            if (!rvalid) begin
                rvalid <= 1'b1;
                rdata  <= mem[rd_ptr];
            end else if (rrdy) begin
                if (rd_ptr == len - AW'(1)) begin
                    rvalid <= 1'b0;
                    full   <= 1'b0;
                    rd_ptr <= '0;
                end else begin
                    rd_ptr <= rd_ptr + AW'(1);
                    rdata  <= mem[rd_ptr + AW'(1)];
                end
            end
        end
    end

endmodule

// File: tb/tb_rcvr_frame_ctrl.sv
// Directed self-checking bench for rcvr_frame_ctrl with a drain-side scoreboard.
module tb_rcvr_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid, cardet, rx_error;
    logic [7:0] mac;
    logic [7:0] rdata;
    logic       rvalid, rrdy;
    logic       ack_needed, ack_received;
    logic [7:0] ack_addr, rerrcnt;

    int         n_checks = 0;
    int         n_errors = 0;
    int         ack_need_cnt = 0;
    int         ack_rcv_cnt = 0;
    int         exp_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] frame_q[$];

    always #5 clk = ~clk;

    rcvr_frame_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .cardet       (cardet),
        .rx_error     (rx_error),
        .mac          (mac),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .rrdy         (rrdy),
        .ack_needed   (ack_needed),
        .ack_addr     (ack_addr),
        .ack_received (ack_received),
        .rerrcnt      (rerrcnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference CRC-8, poly x^8+x^2+x+1.
    function automatic logic [7:0] crc_bits(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ b[i];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction

    task automatic build(input logic [7:0] dest, input logic [7:0] src, input logic [7:0] ftype,
                         input int n, input logic [7:0] base, input bit bad, input bit expect_drain);
        logic [7:0] c;
        logic [7:0] b;
        frame_q = {};
        frame_q.push_back(dest);
        frame_q.push_back(src);
        frame_q.push_back(ftype);
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i);
            frame_q.push_back(b);
            if (expect_drain) exp_q.push_back(b);
        end
        c = 8'h00;
        foreach (frame_q[i]) c = crc_bits(c, frame_q[i]);
        frame_q.push_back(c);
        if (bad) frame_q[3] = frame_q[3] ^ 8'h01;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int err_at);
        cardet = 1'b1;
        cycles(2);
        foreach (frame_q[i]) begin
            rx_data  = frame_q[i];
            rx_valid = 1'b1;
            rx_error = (i == err_at);
            cycles(1);
            rx_valid = 1'b0;
            rx_error = 1'b0;
            cycles(1);
        end
        cycles(1);
        cardet = 1'b0;
        cycles(6);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !rvalid) break;
            cycles(1);
        end
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    endtask

    // Scoreboard: every transferred byte must match the oldest expected byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (ack_needed) ack_need_cnt++;
            if (ack_received) ack_rcv_cnt++;
            if (rvalid && exp_q.size() == 0) check("unexpected_rvalid", 32'(rvalid), 32'd0);
            else if (rvalid && rrdy) check("drain_data", 32'(rdata), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; cardet = 1'b0; rx_error = 1'b0;
        mac = 8'h41; rrdy = 1'b1;
        cycles(3);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_ack_needed", 32'(ack_needed), 32'd0);
        check("rst_ack_received", 32'(ack_received), 32'd0);
        check("rst_ack_addr", 32'(ack_addr), 32'd0);
        check("rst_rerrcnt", 32'(rerrcnt), 32'd0);
        rst = 1'b0;
        cycles(2);

        build(8'h41, 8'h42, 8'h31, 2, 8'h48, 1'b0, 1'b1);
        send_frame(-1);
        wait_drain("good");
        check("good_errcnt", 32'(rerrcnt), 32'd0);

        ack_need_cnt = 0;
        build(8'h41, 8'h42, 8'h32, 3, 8'h61, 1'b0, 1'b1);
        send_frame(-1);
        wait_drain("ackreq");
        check("ackreq_pulses", 32'(ack_need_cnt), 32'd1);
        check("ackreq_addr", 32'(ack_addr), 32'h42);

        build(8'h41, 8'h42, 8'h33, 0, 8'h00, 1'b0, 1'b0);
        send_frame(-1);
        check("ack_rcv_pulses", 32'(ack_rcv_cnt), 32'd1);
        check("ack_errcnt", 32'(rerrcnt), 32'd0);

        build(8'h2A, 8'h43, 8'h31, 4, 8'h70, 1'b0, 1'b1);
        send_frame(-1);
        wait_drain("bcast");

        build(8'h41, 8'h42, 8'h31, 2, 8'h48, 1'b1, 1'b0);
        send_frame(-1);
        exp_err++;
        check("badcrc_errcnt", 32'(rerrcnt), 32'(exp_err));

`ifdef RCVR_PROMISC_EN
        build(8'h55, 8'h42, 8'h31, 2, 8'h48, 1'b1, 1'b0);
        send_frame(-1);
        exp_err++;
        check("badcrc_other_errcnt", 32'(rerrcnt), 32'(exp_err));
        build(8'h55, 8'h42, 8'h31, 2, 8'h50, 1'b0, 1'b1);
        send_frame(-1);
        wait_drain("other_good");
`else
        build(8'h55, 8'h42, 8'h31, 2, 8'h48, 1'b1, 1'b0);
        send_frame(-1);
        check("badcrc_other_errcnt", 32'(rerrcnt), 32'(exp_err));
        build(8'h55, 8'h42, 8'h31, 2, 8'h50, 1'b0, 1'b0);
        send_frame(-1);
        check("filtered_errcnt", 32'(rerrcnt), 32'(exp_err));
`endif

        rrdy = 1'b0;
        build(8'h41, 8'h42, 8'h31, 5, 8'h30, 1'b0, 1'b1);
        send_frame(-1);
        check("busy_first_rvalid", 32'(rvalid), 32'd1);
        build(8'h41, 8'h42, 8'h31, 5, 8'h90, 1'b0, 1'b0);
        send_frame(-1);
        exp_err++;
        check("busy_errcnt", 32'(rerrcnt), 32'(exp_err));
        rrdy = 1'b1;
        wait_drain("busy_drain");

        build(8'h41, 8'h42, 8'h31, 300, 8'h00, 1'b0, 1'b0);
        send_frame(-1);
        exp_err++;
        check("overflow_errcnt", 32'(rerrcnt), 32'(exp_err));

        build(8'h41, 8'h42, 8'h31, 255, 8'h01, 1'b0, 1'b1);
        send_frame(-1);
        wait_drain("maxlen");
        check("maxlen_errcnt", 32'(rerrcnt), 32'(exp_err));

        frame_q = {8'h41, 8'h42, 8'h31};
        send_frame(-1);
        exp_err++;
        check("runt_errcnt", 32'(rerrcnt), 32'(exp_err));

        build(8'h41, 8'h42, 8'h31, 3, 8'h20, 1'b0, 1'b0);
        send_frame(4);
        exp_err++;
        check("rxerr_errcnt", 32'(rerrcnt), 32'(exp_err));

        for (int i = 0; i < 260; i++) begin
            build(8'h41, 8'h42, 8'h31, 1, 8'h10, 1'b1, 1'b0);
            send_frame(-1);
        end
        check("sat_errcnt", 32'(rerrcnt), 32'd255);

        rrdy = 1'b0;
        build(8'h41, 8'h42, 8'h31, 3, 8'hA0, 1'b0, 1'b1);
        send_frame(-1);
        check("middrain_rvalid", 32'(rvalid), 32'd1);
        exp_q = {};
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_errcnt", 32'(rerrcnt), 32'd0);
        rrdy = 1'b1;
        cycles(10);
        check("post_reset_rvalid", 32'(rvalid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
